// File: rtl/fnd_scan_drv.sv
// ---------------------------------------------------------------------------
// fnd_scan_drv
//
// Time-multiplexed scan driver for a 6-digit common-cathode 7-segment (FND)
// display. Each digit is lit for SHOW_CYC clocks. All digits are then dark for
// BLANK_CYC clocks before the next digit is lit. This blanking gap removes
// ghosting caused by segment/enable switching skew.
//
// Frame coherence: the digit codes, DP mask and leading-zero flag are captured
// into a snapshot on the BLANK->SHOW edge of digit 0. Digit 0 itself is decoded
// from the live inputs on that edge. Digits 1..5 come from the snapshot, so one
// frame never mixes values from two different input words.
//
// Parameters
//   SHOW_CYC   clocks each digit is enabled (>= 1)
//   BLANK_CYC  clocks all digits are off between two digits (>= 1)
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   i_digits    six 4-bit codes, [4k+3:4k] = digit k, digit 0 is rightmost
//   i_dp_mask   bit k lights the decimal point of digit k
//   i_blank_lz  1 = blank leading zeros (digit 0 is never blanked)
//   i_disp_en   0 = display off; scan restarts from digit 0 when re-enabled
//   o_seg       segments {a,b,c,d,e,f,g} = [6:0], active-high, registered
//   o_seg_dp    decimal point, active-high, registered
//   o_seg_enb   digit enables, active-low one-hot (bit k = digit k), registered
// ---------------------------------------------------------------------------
module fnd_scan_drv #(
    parameter int SHOW_CYC  = 8000,
    parameter int BLANK_CYC = 330
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_digits,
    input  logic [5:0]  i_dp_mask,
    input  logic        i_blank_lz,
    input  logic        i_disp_en,
    output logic [6:0]  o_seg,
    output logic        o_seg_dp,
    output logic [5:0]  o_seg_enb
);

    // -----------------------------------------------------------------------
    // Interval counter sizing. One counter serves both phases, so it is as
    // wide as the larger of the two terminal counts needs. The terminal count
    // is matched exactly, so the counter never wraps.
    // -----------------------------------------------------------------------
    localparam int SHOW_W  = (SHOW_CYC  > 1) ? $clog2(SHOW_CYC)  : 1;
    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int CNT_W   = (SHOW_W > BLANK_W) ? SHOW_W : BLANK_W;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    localparam int          NUM_DIG  = 6;
    localparam logic [2:0]  LAST_IDX = 3'd5;
    localparam logic [5:0]  ENB_OFF  = 6'h3F;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    scan_state_t        state_q;
    logic [2:0]         idx_q;          // digit that is shown / shown next
    logic [CNT_W-1:0]   cnt_q;          // clocks spent in the current phase

    logic [23:0]        snap_digits_q;  // frame snapshot
    logic [5:0]         snap_dp_q;
    logic               snap_lz_q;

    logic [6:0]         seg_q;
    logic               dp_q;
    logic [5:0]         enb_q;

    // -----------------------------------------------------------------------
    // Hex to 7-segment decode, segment order {a,b,c,d,e,f,g}
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;   // 4'hF
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // Snapshot views, padded to 8 entries so that a 3-bit index is always
    // in range. Entries 6 and 7 are never selected by the scan.
    // -----------------------------------------------------------------------
    logic [3:0] snap_code [8];
    logic [7:0] digit_zero;     // snapshot digit k equals 0x0
    logic [7:0] zero_tail;      // snapshot digits k..5 all equal 0x0
    logic [7:0] snap_dp_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_snap_code
            assign snap_code[gi]  = snap_digits_q[4*gi +: 4];
            assign digit_zero[gi] = (snap_digits_q[4*gi +: 4] == 4'h0);
        end
        for (gi = NUM_DIG; gi < 8; gi++) begin : g_snap_pad
            assign snap_code[gi]  = 4'h0;
            assign digit_zero[gi] = 1'b0;
            assign zero_tail[gi]  = 1'b0;
        end

        // A digit is a leading zero when it and every more significant
        // digit are zero. Build that as a chain from digit 5 downwards.
        assign zero_tail[NUM_DIG-1] = digit_zero[NUM_DIG-1];
        for (gi = 0; gi < NUM_DIG - 1; gi++) begin : g_zero_tail
            assign zero_tail[gi] = digit_zero[gi] & zero_tail[gi+1];
        end
    endgenerate

    assign snap_dp_ext = {2'b00, snap_dp_q};

    // -----------------------------------------------------------------------
    // Values to load on the next BLANK->SHOW edge for digit idx_q.
    // For digit 0 the snapshot is loaded on that same edge, so its code and
    // DP come straight from the live inputs. Digit 0 is never zero-blanked,
    // so the leading-zero flag only ever matters from the snapshot.
    // -----------------------------------------------------------------------
    logic [3:0] code_d;
    logic       suppress_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [5:0] enb_d;
    logic [2:0] idx_d;

    always_comb begin
        code_d     = snap_code[idx_q];
        dp_d       = snap_dp_ext[idx_q];
        suppress_d = snap_lz_q && zero_tail[idx_q];
        if (idx_q == 3'd0) begin
            code_d     = i_digits[3:0];
            dp_d       = i_dp_mask[0];
            suppress_d = 1'b0;
        end
        seg_d = suppress_d ? 7'h00 : seg_decode(code_d);
        // Blanked digits still drive their enable, which keeps the scan
        // duty cycle (and so the brightness) the same for every digit.
        enb_d = ~(6'b00_0001 << idx_q);
        idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end

    // -----------------------------------------------------------------------
    // Scan FSM with registered outputs. Outputs change only on the phase
    // edges and stay constant for the whole SHOW or BLANK interval.
    // Reset has priority over the display enable. A low display enable
    // forces the same state as reset except that the snapshot is left
    // alone; it is reloaded before it is used again anyway.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= ST_BLANK;
            idx_q         <= 3'd0;
            cnt_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            seg_q         <= 7'h00;
            dp_q          <= 1'b0;
            enb_q         <= ENB_OFF;
        end else if (!i_disp_en) begin
            state_q <= ST_BLANK;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            enb_q   <= ENB_OFF;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ST_SHOW;
                        cnt_q   <= '0;
                        seg_q   <= seg_d;
                        dp_q    <= dp_d;
                        enb_q   <= enb_d;
                        if (idx_q == 3'd0) begin
                            snap_digits_q <= i_digits;
                            snap_dp_q     <= i_dp_mask;
                            snap_lz_q     <= i_blank_lz;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        idx_q   <= idx_d;
                        seg_q   <= 7'h00;
                        dp_q    <= 1'b0;
                        enb_q   <= ENB_OFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_seg     = seg_q;
    assign o_seg_dp  = dp_q;
    assign o_seg_enb = enb_q;

endmodule

// File: tb/tb_fnd_scan_drv.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_drv
//
// Bench for fnd_scan_drv with SHOW_CYC=4 and BLANK_CYC=2. Each scenario queues
// the expected sequence of output runs. A run is a {enable, segments, dp}
// value together with the number of clocks it is held. Outputs are sampled on
// the falling edge and grouped into runs. Each completed run is popped from
// the queue and compared.
// ---------------------------------------------------------------------------
module tb_fnd_scan_drv;

    localparam int SHOW  = 4;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] i_digits = 24'h0;
    logic [5:0]  i_dp_mask = 6'h0;
    logic        i_blank_lz = 1'b0;
    logic        i_disp_en = 1'b1;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [5:0]  o_seg_enb;

    always #10 clk = ~clk;

    fnd_scan_drv #(
        .SHOW_CYC (SHOW),
        .BLANK_CYC(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_digits  (i_digits),
        .i_dp_mask (i_dp_mask),
        .i_blank_lz(i_blank_lz),
        .i_disp_en (i_disp_en),
        .o_seg     (o_seg),
        .o_seg_dp  (o_seg_dp),
        .o_seg_enb (o_seg_enb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [13:0] val;   // {enb[5:0], seg[6:0], dp}
        int          len;
    } run_t;

    typedef struct {
        int          at;
        logic [23:0] digits;
        logic        en;
        logic        rst;
    } act_t;

    run_t exp_q[$];
    act_t act_q[$];
    int   exp_total = 0;

    task automatic push_run(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int len);
        run_t r;
        r.val = {enb, seg, dp};
        r.len = len;
        exp_q.push_back(r);
        exp_total += len;
    endtask

    task automatic push_off(input int len);
        push_run(6'h3F, 7'h00, 1'b0, len);
    endtask

    task automatic push_dig(input int k, input logic [6:0] seg, input logic dp, input int len);
        logic [5:0] enb;
        enb = 6'h3F ^ (6'h01 << k);
        push_run(enb, seg, dp, len);
    endtask

    // Normal gap followed by a full digit interval.
    task automatic push_std(input int k, input logic [6:0] seg, input logic dp);
        push_off(BLANK);
        push_dig(k, seg, dp, SHOW);
    endtask

    task automatic add_act(input int at, input logic [23:0] digits, input logic en, input logic rst);
        act_t a;
        a.at = at;
        a.digits = digits;
        a.en = en;
        a.rst = rst;
        act_q.push_back(a);
    endtask

    // Hold reset for three clocks, then check the reset output state.
    task automatic do_reset(input string name);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val($sformatf("%s_rst_enb", name), 32'(o_seg_enb), 32'h3F);
        check_val($sformatf("%s_rst_seg", name), 32'(o_seg), 32'h00);
        check_val($sformatf("%s_rst_dp", name), 32'(o_seg_dp), 32'h0);
    endtask

    task automatic close_run(input string name, input int nrun, input logic [13:0] val, input int len);
        run_t r;
        $display("run %s#%0d enb=%02h seg=%02h dp=%0d len=%0d",
                 name, nrun, val[13:8], val[7:1], val[0], len);
        check_val($sformatf("%s#%0d_expected", name, nrun), 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check_val($sformatf("%s#%0d_value", name, nrun), 32'(val), 32'(r.val));
            check_val($sformatf("%s#%0d_len", name, nrun), 32'(len), 32'(r.len));
        end
    endtask

    // Releases reset after the first sample, then samples once per clock
    // until one clock past the last expected run so that run gets closed.
    // The run still open at the end is not judged.
    task automatic run_phase(input string name);
        int          total;
        int          run_len;
        int          nrun;
        logic [13:0] cur;
        logic [13:0] run_val;
        total   = exp_total + 1;
        run_len = 0;
        nrun    = 0;
        run_val = '0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            cur = {o_seg_enb, o_seg, o_seg_dp};
            if (i == 0) begin
                run_val = cur;
                run_len = 1;
            end else if (cur === run_val) begin
                run_len++;
            end else begin
                close_run(name, nrun, run_val, run_len);
                nrun++;
                run_val = cur;
                run_len = 1;
            end
            if (i == 0) rst_n = 1'b0;
            foreach (act_q[j]) begin
                if (act_q[j].at == i) begin
                    i_digits  = act_q[j].digits;
                    i_disp_en = act_q[j].en;
                    rst_n     = act_q[j].rst;
                end
            end
        end
        check_val($sformatf("%s_leftover", name), 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        act_q.delete();
        exp_total = 0;
    endtask

    task automatic setup(input logic [23:0] digits, input logic [5:0] dp, input logic lz);
        i_digits   = digits;
        i_dp_mask  = dp;
        i_blank_lz = lz;
        i_disp_en  = 1'b1;
    endtask

    initial begin
        // Reset, then scan order over one full frame plus digit 0 again
        setup(24'h123456, 6'h00, 1'b0);
        do_reset("scan");
        push_std(0, 7'h5F, 1'b0);
        push_std(1, 7'h5B, 1'b0);
        push_std(2, 7'h33, 1'b0);
        push_std(3, 7'h79, 1'b0);
        push_std(4, 7'h6D, 1'b0);
        push_std(5, 7'h30, 1'b0);
        push_std(0, 7'h5F, 1'b0);
        run_phase("scan");

        // Inputs change while digit 2 is shown: rest of frame keeps old values
        setup(24'h123456, 6'h00, 1'b0);
        do_reset("tear");
        add_act(15, 24'h654321, 1'b1, 1'b0);
        push_std(0, 7'h5F, 1'b0);
        push_std(1, 7'h5B, 1'b0);
        push_std(2, 7'h33, 1'b0);
        push_std(3, 7'h79, 1'b0);
        push_std(4, 7'h6D, 1'b0);
        push_std(5, 7'h30, 1'b0);
        push_std(0, 7'h30, 1'b0);
        push_std(1, 7'h6D, 1'b0);
        run_phase("tear");

        // Leading-zero blanking
        setup(24'h000700, 6'h00, 1'b1);
        do_reset("lz");
        push_std(0, 7'h7E, 1'b0);
        push_std(1, 7'h7E, 1'b0);
        push_std(2, 7'h70, 1'b0);
        push_std(3, 7'h00, 1'b0);
        push_std(4, 7'h00, 1'b0);
        push_std(5, 7'h00, 1'b0);
        push_std(0, 7'h7E, 1'b0);
        run_phase("lz");

        setup(24'h000000, 6'h00, 1'b1);
        do_reset("lz0");
        push_std(0, 7'h7E, 1'b0);
        for (int k = 1; k < 6; k++) push_std(k, 7'h00, 1'b0);
        push_std(0, 7'h7E, 1'b0);
        run_phase("lz0");

        // Hex codes with one decimal point
        setup(24'hABCDEF, 6'b000100, 1'b0);
        do_reset("hex");
        push_std(0, 7'h47, 1'b0);
        push_std(1, 7'h4F, 1'b0);
        push_std(2, 7'h3D, 1'b1);
        push_std(3, 7'h4E, 1'b0);
        push_std(4, 7'h1F, 1'b0);
        push_std(5, 7'h77, 1'b0);
        push_std(0, 7'h47, 1'b0);
        run_phase("hex");

        // Display disabled during digit 3, new value loaded while off
        setup(24'h123456, 6'h00, 1'b0);
        do_reset("en");
        add_act(21, 24'h654321, 1'b0, 1'b0);
        add_act(26, 24'h654321, 1'b1, 1'b0);
        push_std(0, 7'h5F, 1'b0);
        push_std(1, 7'h5B, 1'b0);
        push_std(2, 7'h33, 1'b0);
        push_off(BLANK);
        push_dig(3, 7'h79, 1'b0, 2);
        push_off(6);
        push_dig(0, 7'h30, 1'b0, SHOW);
        push_std(1, 7'h6D, 1'b0);
        run_phase("en");

        // Same sequence with a reset pulse instead of the enable
        setup(24'h123456, 6'h00, 1'b0);
        do_reset("mrst");
        add_act(21, 24'h654321, 1'b1, 1'b1);
        add_act(26, 24'h654321, 1'b1, 1'b0);
        push_std(0, 7'h5F, 1'b0);
        push_std(1, 7'h5B, 1'b0);
        push_std(2, 7'h33, 1'b0);
        push_off(BLANK);
        push_dig(3, 7'h79, 1'b0, 2);
        push_off(6);
        push_dig(0, 7'h30, 1'b0, SHOW);
        push_std(1, 7'h6D, 1'b0);
        run_phase("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
